// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: latches a byte and its parity settings, paces the
// serializer, and sequences the line through START, DATA, optional PARITY and STOP.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame_ctrl: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    accept;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    // The final STOP cycle doubles as an accept slot so frames can run back to back.
    assign accept = Data_Valid &&
                    ((state_q == IDLE) || ((state_q == STOP) && (cnt_q == LAST_STOP)));

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        TX_OUT    = 1'b1;
        Busy      = 1'b0;
        ser_en    = 1'b0;

        unique case (state_q)
            IDLE: ;
            START: begin
                TX_OUT  = 1'b0;
                Busy    = 1'b1;
                ser_en  = 1'b1;
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                TX_OUT = ser_data;
                Busy   = 1'b1;
                ser_en = (cnt_q != LAST_DATA);
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                TX_OUT  = (^data_q) ^ par_typ_q;
                Busy    = 1'b1;
                cnt_d   = '0;
                state_d = STOP;
            end
            STOP: begin
                Busy = 1'b1;
                if (cnt_q == LAST_STOP) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
            state_d   = START;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed bench: two controllers (1 and 2 stop bits) with a behavioural serializer each,
// line bits compared against hand-written frame patterns.
module tb_uart_tx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       PAR_EN, PAR_TYP;
    logic       dv1, dv2;
    logic       ser_data1 = 1'b0, ser_data2 = 1'b0;
    logic       ser_en1, ser_en2;
    logic       tx1, tx2, busy1, busy2;
    logic [7:0] ser_word = 8'h00;
    int         k1 = 0, k2 = 0;
    int         n_vec = 0, n_err = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(dv1),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data1),
        .ser_en(ser_en1), .TX_OUT(tx1), .Busy(busy1)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(dv2),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data2),
        .ser_en(ser_en2), .TX_OUT(tx2), .Busy(busy2)
    );

    // Serializer models: bit k of the frame word appears the cycle after the k-th ser_en.
    always @(posedge CLK) begin
        if (ser_en1) begin
            ser_data1 <= ser_word[k1[2:0]];
            k1        <= k1 + 1;
        end else begin
            k1 <= 0;
        end
    end

    always @(posedge CLK) begin
        if (ser_en2) begin
            ser_data2 <= ser_word[k2[2:0]];
            k2        <= k2 + 1;
        end else begin
            k2 <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge inside the START cycle.
    task automatic send(input int which, input logic [7:0] data, input logic pe, input logic pt);
        P_DATA   = data;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        ser_word = data;
        if (which == 1) dv1 = 1'b1; else dv2 = 1'b1;
        @(negedge CLK);
        dv1 = 1'b0;
        dv2 = 1'b0;
    endtask

    // mode 0: plain, 1: chain a 3C frame in the final STOP cycle,
    // 2: Data_Valid pulses mid-DATA, 3: toggle inputs every cycle.
    task automatic frame(input int which, input logic [15:0] exp, input int len,
                         input string tag, input int mode);
        int en_cnt;
        en_cnt = 0;
        for (int i = 0; i < len; i++) begin
            logic t, b, e;
            t = (which == 1) ? tx1 : tx2;
            b = (which == 1) ? busy1 : busy2;
            e = (which == 1) ? ser_en1 : ser_en2;
            check($sformatf("%s tx[%0d]", tag, i), 32'(t), 32'(exp[len-1-i]));
            check($sformatf("%s busy[%0d]", tag, i), 32'(b), 32'd1);
            if (e) en_cnt++;
            case (mode)
                1: if (i == len - 1) begin
                    dv1 = 1'b1; P_DATA = 8'h3C; PAR_EN = 1'b0; ser_word = 8'h3C;
                end
                2: if (i == 3 || i == 6) begin
                    dv1 = 1'b1; P_DATA = 8'h00;
                end else begin
                    dv1 = 1'b0;
                end
                3: begin
                    P_DATA = ~P_DATA; PAR_EN = ~PAR_EN; PAR_TYP = ~PAR_TYP;
                end
                default: ;
            endcase
            @(negedge CLK);
        end
        check($sformatf("%s ser_en_count", tag), 32'(en_cnt), 32'd8);
        if (mode != 1) begin
            check($sformatf("%s idle_tx", tag), 32'((which == 1) ? tx1 : tx2), 32'd1);
            check($sformatf("%s idle_busy", tag), 32'((which == 1) ? busy1 : busy2), 32'd0);
        end
    endtask

    initial begin
        RST = 1'b1; dv1 = 1'b0; dv2 = 1'b0;
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst tx1", 32'(tx1), 32'd1);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst ser_en1", 32'(ser_en1), 32'd0);
        check("rst tx2", 32'(tx2), 32'd1);
        check("rst busy2", 32'(busy2), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        send(1, 8'hA5, 1'b1, 1'b0);
        frame(1, 16'b00000_01010010101, 11, "a5_even", 0);
        send(1, 8'hA5, 1'b1, 1'b1);
        frame(1, 16'b00000_01010010111, 11, "a5_odd", 0);
        send(1, 8'hA5, 1'b0, 1'b0);
        frame(1, 16'b000000_0101001011, 10, "a5_nopar", 0);

        send(2, 8'hFF, 1'b1, 1'b0);
        frame(2, 16'b0000_011111111011, 12, "ff_stop2", 0);

        send(1, 8'hA5, 1'b0, 1'b0);
        frame(1, 16'b000000_0101001011, 10, "chain_a5", 1);
        dv1 = 1'b0;
        frame(1, 16'b000000_0001111001, 10, "chain_3c", 0);

        send(1, 8'hA5, 1'b1, 1'b0);
        frame(1, 16'b00000_01010010101, 11, "dv_glitch", 2);
        dv1 = 1'b0;

        send(1, 8'h01, 1'b1, 1'b1);
        frame(1, 16'b00000_01000000001, 11, "toggle", 3);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;

        send(1, 8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        check("mid busy", 32'(busy1), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort tx", 32'(tx1), 32'd1);
        check("abort busy", 32'(busy1), 32'd0);
        check("abort ser_en", 32'(ser_en1), 32'd0);
        @(negedge CLK);
        check("abort stays idle tx", 32'(tx1), 32'd1);
        check("abort stays idle busy", 32'(busy1), 32'd0);
        send(1, 8'hA5, 1'b1, 1'b0);
        frame(1, 16'b00000_01010010101, 11, "post_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Frame controller for the UART transmit path, placed directly around the serializer block. It accepts a parallel byte on a valid strobe, latches the data and parity settings, and drives the serializer enable. It sequences the line through START, DATA, optional PARITY and STOP bits, and muxes the serial line output. One CLK cycle equals one bit period; the baud divider sits upstream and gates CLK-domain pacing.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; also the width of P_DATA.
STOP_BITS, 1, number of stop-bit periods; only 1 or 2 are legal.

Ports:
CLK  input  1  bit-rate clock
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel data to transmit
Data_Valid  input  1  P_DATA valid strobe; one frame is accepted per accepting cycle
PAR_EN  input  1  1 = parity bit included in the frame
PAR_TYP  input  1  0 = even parity, 1 = odd parity
ser_data  input  1  serial bit from the serializer, LSB first, valid one cycle after each ser_en cycle
ser_en  output  1  serializer shift request
TX_OUT  output  1  UART serial line, idles high
Busy  output  1  frame in progress

Behaviour:
- Reset: RST is sampled on the CLK rising edge.
  - state=IDLE; TX_OUT=1, Busy=0, ser_en=0.
  - Latched data, parity-enable and parity-type registers = 0; bit counter = 0.
  - RST mid-frame aborts the frame. TX_OUT is 1 on the cycle after the reset edge; no partial bits follow.
- Output decode: TX_OUT, Busy and ser_en are decoded from the state and counter (Moore). TX_OUT in DATA passes ser_data straight through.
- Accept condition: Data_Valid=1 while state=IDLE, or while in the final STOP cycle.
  - On accept, latch P_DATA, PAR_EN and PAR_TYP. The next state is START.
  - Data_Valid in any other cycle is ignored. No queueing; no effect on the current frame.
- State sequence:
  - IDLE: TX_OUT=1, Busy=0, ser_en=0.
  - START: lasts 1 cycle. TX_OUT=0, Busy=1, ser_en=1. Clear the bit counter, then go to DATA.
  - DATA: lasts exactly DATA_WIDTH cycles, counted internally with a $clog2(DATA_WIDTH)-bit counter.
    - TX_OUT=ser_data, Busy=1.
    - ser_en=1 for DATA cycles 0..DATA_WIDTH-2 and 0 on the last DATA cycle. ser_en is therefore high for exactly DATA_WIDTH cycles per frame, START included.
    - On the last cycle, go to PARITY if the latched PAR_EN=1, otherwise to STOP.
  - PARITY: lasts 1 cycle. TX_OUT = XOR-reduce(latched data) XOR latched PAR_TYP. Busy=1, ser_en=0. Then go to STOP.
  - STOP: lasts STOP_BITS cycles. TX_OUT=1, Busy=1, ser_en=0.
    - After the final STOP cycle, go to IDLE.
    - If Data_Valid=1 in the final STOP cycle, go to START instead (back-to-back frames with no idle gap).
- Parity source: parity is computed only from the latched copy. Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect.
- Frame length: 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles, with Busy high for exactly that many cycles.
- Latency: accept edge -> START on the line at the next cycle.
- Serializer contract: ser_data carries bit k of the latched word in the cycle after the k-th ser_en-high cycle of the frame.
- Illegal STOP_BITS: a value other than 1 or 2 is a synthesis/elaboration error.

Test Plan:
- Reset, then P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high for those 11 cycles; ser_en high for 8 cycles.
- Same data, PAR_TYP=1 -> parity bit = 1; PAR_EN=0 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1 with no parity bit.
- STOP_BITS=2, P_DATA=8'hFF, PAR_EN=1, even parity -> 0, eight 1s, 0, 1, 1; Busy high for 12 cycles.
- Data_Valid=1 with P_DATA=8'h3C in the final STOP cycle of an 8'hA5 frame -> START (0) on the very next cycle with no idle-high gap; second frame carries 3C. Data_Valid pulses mid-DATA are ignored.
- P_DATA, PAR_EN and PAR_TYP toggled every cycle during a frame carrying 8'h01 with odd parity -> data and parity bits unaffected; parity bit = 0.
- RST asserted in DATA cycle 3 -> next cycle TX_OUT=1, Busy=0, ser_en=0, state IDLE; a new Data_Valid then produces a clean full frame.
